stream_mux_2to1: RTL and testbench

//   Two-input, one-output registered stream merger; the return path for the 1:2 demux.

---
 rtl/stream_mux_2to1.sv | 67 ++++++
 tb/tb_stream_mux_2to1.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/stream_mux_2to1.sv
// stream_mux_2to1: registered 2:1 valid/ready stream merger, round-robin or fixed priority; MUX_COUNT_EN adds per-channel beat counters
module stream_mux_2to1 #(
  parameter int WIDTH    = 8,
  parameter bit PRIORITY = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  output logic             out_valid,
  input  logic             out_ready
`ifdef MUX_COUNT_EN
  ,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
`endif
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nxt;
  logic last_grant, load_ok, grant1, acc0, acc1, accept;
  assign out_valid = state == FULL;
  // grant selection, readies and next occupancy of the output register
  always_comb begin
    load_ok   = state == EMPTY || out_ready;
    grant1    = in1_valid && (!in0_valid || (!PRIORITY && !last_grant));
    in0_ready = rst_n && load_ok && in0_valid && !grant1;
    in1_ready = rst_n && load_ok && grant1;
    acc0      = in0_valid && in0_ready;
    acc1      = in1_valid && in1_ready;
    accept    = acc0 || acc1;
    state_nxt = accept ? FULL : (out_ready ? EMPTY : state);
  end
  // output register; a held beat is discarded by reset and channel 0 wins first after it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      out_data   <= '0;
      out_sel    <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (accept) begin
        out_data   <= acc1 ? in1_data : in0_data;
        out_sel    <= acc1;
        last_grant <= acc1;
      end
    end
  end
`ifdef MUX_COUNT_EN
  // accepted-beat counters per channel, wrapping at 16 bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      cnt0 <= cnt0 + 16'(acc0);
      cnt1 <= cnt1 + 16'(acc1);
    end
  end
`endif
endmodule

// File: tb/tb_stream_mux_2to1.sv
// tb_stream_mux_2to1: directed self-checking bench for round-robin and fixed-priority merger instances
module tb_stream_mux_2to1;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] in0_data, in1_data;
  logic in0_valid, in1_valid, out_ready;
  logic in0_ready, in1_ready, out_sel, out_valid;
  logic [7:0] out_data;
  logic p_in0_ready, p_in1_ready, p_out_sel, p_out_valid;
  logic [7:0] p_out_data;
  int compared = 0;
  int mismatched = 0;
`ifdef MUX_COUNT_EN
  logic [15:0] cnt0, cnt1, p_cnt0, p_cnt1;
`endif

  always #5 clk = ~clk;

  stream_mux_2to1 #(.WIDTH(8), .PRIORITY(1'b0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_COUNT_EN
    , .cnt0(cnt0), .cnt1(cnt1)
`endif
  );

  stream_mux_2to1 #(.WIDTH(8), .PRIORITY(1'b1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(p_in0_ready),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(p_in1_ready),
    .out_data(p_out_data), .out_sel(p_out_sel), .out_valid(p_out_valid), .out_ready(out_ready)
`ifdef MUX_COUNT_EN
    , .cnt0(p_cnt0), .cnt1(p_cnt1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in0_valid = 1'b1; in1_valid = 1'b1;
    in0_data = 8'h11; in1_data = 8'h22; out_ready = 1'b1;
    // reset held two cycles with both sources valid
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_sel", out_sel, 0);
      chk("rst_in0_ready", in0_ready, 0);
      chk("rst_in1_ready", in1_ready, 0);
      chk("rst_p_in0_ready", p_in0_ready, 0);
    end
    // single channel stream A5,3C,F0
    rst_n = 1'b1; in1_valid = 1'b0; in0_data = 8'hA5;
    #1;
    chk("single_in0_ready", in0_ready, 1);
    chk("single_in1_ready", in1_ready, 0);
    tick();
    chk("single_valid0", out_valid, 1);
    chk("single_data0", out_data, 8'hA5);
    chk("single_sel0", out_sel, 0);
    in0_data = 8'h3C;
    tick();
    chk("single_data1", out_data, 8'h3C);
    in0_data = 8'hF0;
    tick();
    chk("single_data2", out_data, 8'hF0);
    chk("single_sel2", out_sel, 0);
    in0_valid = 1'b0;
    tick();
    chk("single_drained", out_valid, 0);
    // contention from a fresh reset so channel 0 wins first
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; in0_valid = 1'b1; in1_valid = 1'b1;
    in0_data = 8'h11; in1_data = 8'h22;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_in0_ready", in0_ready, (k % 2 == 0) ? 1 : 0);
      chk("rr_in1_ready", in1_ready, (k % 2 == 1) ? 1 : 0);
      chk("fp_in1_ready", p_in1_ready, 0);
      tick();
      chk("rr_sel", out_sel, k % 2);
      chk("rr_data", out_data, (k % 2 == 1) ? 8'h22 : 8'h11);
      chk("fp_sel", p_out_sel, 0);
      chk("fp_data", p_out_data, 8'h11);
    end
    // backpressure with beat 22 from channel 1 held
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in0_ready", in0_ready, 0);
      chk("stall_in1_ready", in1_ready, 0);
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 8'h22);
      chk("stall_sel", out_sel, 1);
    end
    out_ready = 1'b1; in0_data = 8'h44;
    #1;
    chk("release_in0_ready", in0_ready, 1);
    chk("release_in1_ready", in1_ready, 0);
    tick();
    chk("release_valid", out_valid, 1);
    chk("release_data", out_data, 8'h44);
    chk("release_sel", out_sel, 0);
    // reset mid-stream while 7E is held
    in1_valid = 1'b0; in0_data = 8'h7E;
    tick();
    chk("mid_data", out_data, 8'h7E);
    chk("mid_valid", out_valid, 1);
    rst_n = 1'b0; out_ready = 1'b0;
    tick();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    rst_n = 1'b1; out_ready = 1'b1; in1_valid = 1'b1;
    in0_data = 8'h11; in1_data = 8'h22;
    #1;
    chk("post_rst_in0_ready", in0_ready, 1);
    chk("post_rst_in1_ready", in1_ready, 0);
    tick();
    chk("post_rst_sel", out_sel, 0);
    chk("post_rst_data", out_data, 8'h11);
`ifdef MUX_COUNT_EN
    // beat counters: 5 on channel 0, 3 on channel 1, then wrap
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; in0_valid = 1'b1; in1_valid = 1'b0;
    repeat (5) tick();
    in0_valid = 1'b0; in1_valid = 1'b1;
    repeat (3) tick();
    in1_valid = 1'b0;
    tick();
    chk("cnt0", cnt0, 5);
    chk("cnt1", cnt1, 3);
    force u_rr.cnt0 = 16'hFFFF;
    #1;
    release u_rr.cnt0;
    in0_valid = 1'b1;
    tick();
    in0_valid = 1'b0;
    chk("cnt0_wrap", cnt0, 0);
    chk("cnt1_hold", cnt1, 3);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
